game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller for the side-scrolling pipe game. It sequences play through idle, playing, dying and game-over phases, and gates the background/pipe animation datapath through `run`. It evaluates bird-vs-pipe and floor collisions once per animation frame and keeps the current and high score. It sits between the VGA driver's animation clock, the flap input and the animation/drawing blocks, all in the `CLOCK` domain.

## Interface
Parameters:
- BIRD_X, 550: bird left edge, pixels
- BIRD_W, 40: bird width
- BIRD_H, 30: bird height
- PIPE_W, 60: pipe width
- FLOOR_Y, 450: floor line; bird bottom at or below it is a hit
- DIE_FRAMES, 60: frames spent in DYING
- SCORE_MAX, 999: score saturation value

Ports:
- CLOCK  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low reset
- frameIn  in  1  animation clock level (asynchronous to CLOCK); each rising edge is one frame
- flapIn  in  1  flap button level, active-high, asynchronous
- birdY  in  10  bird top edge
- pipeX  in  10  left edge of the nearest pipe pair
- gapTop  in  10  first open row of the nearest pipe gap
- gapBottom  in  10  last open row of the nearest pipe gap
- run  out  1  1 = animations advance
- state  out  2  0 IDLE, 1 PLAYING, 2 DYING, 3 GAMEOVER
- score  out  10  current score, binary
- highScore  out  10  best score since reset
- birdHide  out  1  1 = bird not drawn (death blink)
- flapPulse  out  1  one-cycle flap strobe to bird physics

## Operation
- **Input conditioning:** `frameIn` and `flapIn` each pass through a 2-FF synchronizer, then a rising-edge detector. This produces internal one-cycle strobes `tick` and `flap`.
- **IDLE:**
  - `run` = 0 and `birdHide` = 0.
  - On `flap`: `score` ← 0, `flapPulse` = 1 for that cycle, `passed` ← 0, go to PLAYING.
- **PLAYING:** `run` = 1; each `flap` produces `flapPulse`. On each `tick`:
  - All sums use 11-bit arithmetic, so there is no wrap.
  - `hOverlap` = (pipeX < BIRD_X+BIRD_W) && (pipeX+PIPE_W > BIRD_X).
  - `hit` = (hOverlap && (birdY < gapTop || birdY+BIRD_H-1 > gapBottom)) || (birdY+BIRD_H >= FLOOR_Y).
  - If `hit`: go to DYING, `dieCnt` ← 0. No score change this tick; hit beats pass.
  - Else, if pipeX+PIPE_W <= BIRD_X and `passed` = 0: `score` ← min(score+1, SCORE_MAX), `passed` ← 1.
  - `passed` ← 0 whenever pipeX >= BIRD_X, i.e. a new pipe has wrapped in.
- **DYING:**
  - `run` = 0; `flap` is ignored and produces no `flapPulse`.
  - Each `tick` increments `dieCnt`. `birdHide` = `dieCnt[3]`, so the bird blinks every 8 frames.
  - On the `tick` where `dieCnt` = DIE_FRAMES-1: go to GAMEOVER, `birdHide` ← 0, and `highScore` ← score if score > highScore.
- **GAMEOVER:**
  - `run` = 0; `score` is held for display.
  - `flap` returns to IDLE without a `flapPulse`. A second flap is needed to start play.
- **Events while an input is held:** a `flap` that lands in the same cycle as a `tick` is processed in parallel, not sequenced. The level of `flapIn` is irrelevant; only its edges count. Holding `flapIn` high across states does not retrigger.
- **Reset:**
  - Values while `reset` = 0, asynchronously: state IDLE, run 0, score 0, highScore 0, birdHide 0, flapPulse 0, dieCnt 0, passed 0, all synchronizer and edge registers 0.
  - Reset mid-game discards the score and does not update highScore.

## Timing
- Internal `tick` and `flap` strobes go high on the 3rd `CLOCK` edge after the input rises (2 synchronizer stages plus 1 edge register).
- `flapPulse` is combinational from `flap` and the state. It is high in that same cycle and lasts exactly 1 cycle.
- State, score, `passed`, `dieCnt`, `highScore` and `birdHide` update on the `CLOCK` edge that ends the strobe cycle. They are visible 4 edges after the input rise.
- `run` is decoded from the registered state and follows it with no added latency.
- `birdY`, `pipeX`, `gapTop` and `gapBottom` are sampled only in the `tick` cycle. They must be stable for the 4 cycles after `frameIn` rises; the animation blocks update on the same edge, which satisfies this.
- Minimum input pulse width or low time is 2 `CLOCK` cycles; shorter pulses may be missed.

## Test plan
- **Reset values:** reset low → all outputs 0 and state 0. Release reset, pulse `flapIn` → `flapPulse` one cycle, 3 edges later; state 1; run 1.
- **Scoring:** PLAYING with birdY=200, gap 150..300; sweep pipeX down from 600 to 400 over ticks → score increments once, on the tick where pipeX ≤ 490. Raise pipeX to 620, sweep again → score 2.
- **Pipe collision:** birdY=100, gap 150..300, pipeX=560, tick → state 2, run 0, score unchanged. After 60 ticks → state 3, highScore = score.
- **Floor collision and hit priority:** birdY=421, no pipe overlap → DYING. Separately, a tick with a pass condition and a floor hit together → score unchanged, state 2.
- **Flap handling in end states:** flap in DYING → no `flapPulse`, state stays 2. In GAMEOVER, first flap → state 0 with no pulse; second flap → state 1, score 0, highScore kept.
- **Saturation and reset mid-game:** score preset to 999 via passes, further pass → stays 999. Assert reset mid-PLAYING → score 0, highScore 0 immediately (asynchronous).

Source files
------------

// File: rtl/game_sequencer.sv
// Game controller for the pipe game: synchronizes frame/flap inputs, sequences
// IDLE/PLAYING/DYING/GAMEOVER, detects collisions per frame and keeps scores.
module game_sequencer #(
  parameter int BIRD_X     = 550,
  parameter int BIRD_W     = 40,
  parameter int BIRD_H     = 30,
  parameter int PIPE_W     = 60,
  parameter int FLOOR_Y    = 450,
  parameter int DIE_FRAMES = 60,
  parameter int SCORE_MAX  = 999
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       frameIn,
  input  logic       flapIn,
  input  logic [9:0] birdY,
  input  logic [9:0] pipeX,
  input  logic [9:0] gapTop,
  input  logic [9:0] gapBottom,
  output logic       run,
  output logic [1:0] state,
  output logic [9:0] score,
  output logic [9:0] highScore,
  output logic       birdHide,
  output logic       flapPulse
);

  // dieCnt[3] drives the blink, so the counter never narrows below 4 bits.
  localparam int DW = ($clog2(DIE_FRAMES) < 4) ? 4 : $clog2(DIE_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAYING  = 2'd1,
    DYING    = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t          cur_state, nxt_state;
  logic [2:0]      frame_sr, flap_sr;
  logic            tick, flap;
  logic [9:0]      score_q, score_d, high_q, high_d;
  logic            passed_q, passed_d, hide_q, hide_d;
  logic [DW-1:0]   die_q, die_d;
  logic [10:0]     by, px, gt, gb;
  logic            h_overlap, hit, pass_ok, wrapped;

  // Two synchronizer stages, a history stage, then a registered edge strobe.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      frame_sr <= '0;
      flap_sr  <= '0;
      tick     <= 1'b0;
      flap     <= 1'b0;
    end else begin
      frame_sr <= {frame_sr[1:0], frameIn};
      flap_sr  <= {flap_sr[1:0], flapIn};
      tick     <= frame_sr[1] & ~frame_sr[2];
      flap     <= flap_sr[1] & ~flap_sr[2];
    end
  end

  // 11-bit operands so pipe/bird sums never wrap.
  assign by = {1'b0, birdY};
  assign px = {1'b0, pipeX};
  assign gt = {1'b0, gapTop};
  assign gb = {1'b0, gapBottom};

  assign h_overlap = (px < 11'(BIRD_X + BIRD_W)) && (px + 11'(PIPE_W) > 11'(BIRD_X));
  assign hit       = (h_overlap && ((by < gt) || (by + 11'(BIRD_H - 1) > gb)))
                   || (by + 11'(BIRD_H) >= 11'(FLOOR_Y));
  assign pass_ok   = (px + 11'(PIPE_W) <= 11'(BIRD_X));
  assign wrapped   = (px >= 11'(BIRD_X));

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    nxt_state = cur_state;
    score_d   = score_q;
    high_d    = high_q;
    passed_d  = passed_q;
    hide_d    = hide_q;
    die_d     = die_q;
    flapPulse = 1'b0;
    case (cur_state)
      IDLE: begin
        if (flap) begin
          flapPulse = 1'b1;
          score_d   = '0;
          passed_d  = 1'b0;
          nxt_state = PLAYING;
        end
      end
      PLAYING: begin
        flapPulse = flap;
        if (tick) begin
          if (hit) begin
            nxt_state = DYING;
            die_d     = '0;
            hide_d    = 1'b0;
          end else if (pass_ok && !passed_q) begin
            score_d  = (score_q >= 10'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_q + 10'd1;
            passed_d = 1'b1;
          end
          if (wrapped) passed_d = 1'b0;
        end
      end
      DYING: begin
        if (tick) begin
          if (die_q == DW'(DIE_FRAMES - 1)) begin
            nxt_state = GAMEOVER;
            hide_d    = 1'b0;
            die_d     = '0;
            if (score_q > high_q) high_d = score_q;
          end else begin
            die_d  = die_q + DW'(1);
            hide_d = die_d[3];
          end
        end
      end
      GAMEOVER: begin
        if (flap) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      score_q  <= '0;
      high_q   <= '0;
      passed_q <= 1'b0;
      hide_q   <= 1'b0;
      die_q    <= '0;
    end else begin
      score_q  <= score_d;
      high_q   <= high_d;
      passed_q <= passed_d;
      hide_q   <= hide_d;
      die_q    <= die_d;
    end
  end

  assign run       = (cur_state == PLAYING);
  assign state     = cur_state;
  assign score     = score_q;
  assign highScore = high_q;
  assign birdHide  = hide_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a game-rules model is compared to every output on
// every falling clock edge, with literal checks at the key scenario points.
module tb_game_sequencer;

  localparam int BIRD_X     = 550;
  localparam int BIRD_W     = 40;
  localparam int BIRD_H     = 30;
  localparam int PIPE_W     = 60;
  localparam int FLOOR_Y    = 450;
  localparam int DIE_FRAMES = 60;
  localparam int SCORE_MAX  = 999;

  logic       CLOCK = 1'b0;
  logic       reset = 1'b1;
  logic       frameIn = 1'b0;
  logic       flapIn = 1'b0;
  logic [9:0] birdY = 10'd200;
  logic [9:0] pipeX = 10'd700;
  logic [9:0] gapTop = 10'd150;
  logic [9:0] gapBottom = 10'd300;
  logic       run;
  logic [1:0] state;
  logic [9:0] score, highScore;
  logic       birdHide, flapPulse;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Model of the game as the player sees it.
  int m_state = 0, m_score = 0, m_high = 0, m_dead_frames = 0;
  bit m_hide = 0, m_passed = 0, exp_pulse = 0, cmp_en = 0;

  always #5 CLOCK = ~CLOCK;

  game_sequencer dut (
    .CLOCK(CLOCK), .reset(reset), .frameIn(frameIn), .flapIn(flapIn),
    .birdY(birdY), .pipeX(pipeX), .gapTop(gapTop), .gapBottom(gapBottom),
    .run(run), .state(state), .score(score), .highScore(highScore),
    .birdHide(birdHide), .flapPulse(flapPulse)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    if (cmp_en) begin
      check("state", int'(state), m_state);
      check("run", int'(run), int'(m_state == 1));
      check("score", int'(score), m_score);
      check("highScore", int'(highScore), m_high);
      check("birdHide", int'(birdHide), int'(m_hide));
      check("flapPulse", int'(flapPulse), int'(exp_pulse));
      if (flapPulse) pulse_cnt++;
    end
  end

  function automatic void model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_dead_frames = 0;
    m_hide = 0; m_passed = 0; exp_pulse = 0;
  endfunction

  // Applies one frame and/or one flap, both judged against the pre-event state.
  function automatic void model_step(input bit tk, input bit fl);
    int  px, byv, s;
    bit  overlap, crash;
    px  = int'(pipeX);
    byv = int'(birdY);
    s   = m_state;
    if (s == 0 && fl) begin
      m_score = 0; m_passed = 0; m_state = 1;
    end else if (s == 1 && tk) begin
      overlap = (px < BIRD_X + BIRD_W) && (px + PIPE_W > BIRD_X);
      crash   = (overlap && (byv < int'(gapTop) || byv + BIRD_H - 1 > int'(gapBottom)))
              || (byv + BIRD_H >= FLOOR_Y);
      if (crash) begin
        m_state = 2; m_dead_frames = 0; m_hide = 0;
      end else if (px + PIPE_W <= BIRD_X && !m_passed) begin
        m_score  = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
        m_passed = 1;
      end
      if (px >= BIRD_X) m_passed = 0;
    end else if (s == 2 && tk) begin
      m_dead_frames++;
      if (m_dead_frames == DIE_FRAMES) begin
        m_state = 3; m_hide = 0;
        if (m_score > m_high) m_high = m_score;
      end else begin
        m_hide = ((m_dead_frames / 8) % 2) == 1;
      end
    end else if (s == 3 && fl) begin
      m_state = 0;
    end
  endfunction

  // Raise the chosen inputs, expect the strobe 3 edges later and the update on the 4th.
  task automatic ev(input bit tk, input bit fl);
    @(negedge CLOCK);
    frameIn = tk;
    flapIn  = fl;
    repeat (3) @(posedge CLOCK);
    #1 exp_pulse = fl && (m_state == 0 || m_state == 1);
    @(posedge CLOCK);
    #1 exp_pulse = 0;
    model_step(tk, fl);
    @(negedge CLOCK);
    frameIn = 1'b0;
    flapIn  = 1'b0;
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic frame(input int by, input int px);
    birdY = 10'(by);
    pipeX = 10'(px);
    ev(1'b1, 1'b0);
  endtask

  task automatic finish_death_and_restart(input int by, input int px);
    repeat (DIE_FRAMES) frame(by, px);
    ev(1'b0, 1'b1);
    ev(1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #11;
    check("rst_state", int'(state), 0);
    check("rst_run", int'(run), 0);
    check("rst_score", int'(score), 0);
    check("rst_high", int'(highScore), 0);
    check("rst_pulse", int'(flapPulse), 0);
    cmp_en = 1;
    @(negedge CLOCK);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK);

    // Start a game.
    ev(1'b0, 1'b1);
    check("start_state", int'(state), 1);
    check("start_run", int'(run), 1);
    check("start_pulses", pulse_cnt, 1);

    // Scoring sweeps with the bird inside the gap.
    gapTop = 10'd150;
    gapBottom = 10'd300;
    for (int px = 600; px >= 400; px -= 10) begin
      frame(200, px);
      if (px == 500) check("score_before_pass", int'(score), 0);
      if (px == 490) check("score_on_pass", int'(score), 1);
    end
    check("score_first", int'(score), 1);
    frame(200, 620);
    birdY = 10'd200;
    pipeX = 10'd600;
    ev(1'b1, 1'b1);
    check("both_pulses", pulse_cnt, 2);
    for (int px = 600; px >= 400; px -= 10) frame(200, px);
    check("score_second", int'(score), 2);

    // Pipe collision, blink and game over.
    frame(100, 560);
    check("pipe_hit_state", int'(state), 2);
    check("pipe_hit_run", int'(run), 0);
    check("pipe_hit_score", int'(score), 2);
    ev(1'b0, 1'b1);
    check("dying_flap_state", int'(state), 2);
    check("dying_flap_pulses", pulse_cnt, 2);
    for (int i = 1; i < DIE_FRAMES; i++) begin
      frame(100, 560);
      if (i == 8)  check("blink_on", int'(birdHide), 1);
      if (i == 16) check("blink_off", int'(birdHide), 0);
    end
    check("dying_59", int'(state), 2);
    frame(100, 560);
    check("gameover_state", int'(state), 3);
    check("gameover_high", int'(highScore), 2);
    check("gameover_hide", int'(birdHide), 0);

    // Game over: first flap to idle without pulse, second starts play.
    ev(1'b0, 1'b1);
    check("go_idle_state", int'(state), 0);
    check("go_idle_score", int'(score), 2);
    check("go_idle_pulses", pulse_cnt, 2);
    ev(1'b0, 1'b1);
    check("restart_state", int'(state), 1);
    check("restart_score", int'(score), 0);
    check("restart_high", int'(highScore), 2);

    // Floor hit with no pipe overlap.
    frame(421, 700);
    check("floor_state", int'(state), 2);
    finish_death_and_restart(421, 700);

    // Pass and floor hit on the same frame: hit wins.
    frame(421, 480);
    check("prio_state", int'(state), 2);
    check("prio_score", int'(score), 0);
    finish_death_and_restart(421, 480);

    // Saturation.
    for (int i = 0; i < SCORE_MAX; i++) begin
      frame(200, 480);
      frame(200, 600);
    end
    check("sat_reach", int'(score), 999);
    frame(200, 480);
    check("sat_hold", int'(score), 999);
    check("sat_high", int'(highScore), 2);

    // Asynchronous reset mid-game.
    @(negedge CLOCK);
    #2;
    model_reset();
    reset = 1'b0;
    #1;
    check("async_score", int'(score), 0);
    check("async_high", int'(highScore), 0);
    check("async_state", int'(state), 0);
    check("async_run", int'(run), 0);
    repeat (3) @(negedge CLOCK);
    cmp_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
